// File: rtl/sseg_mux_if.sv
// sseg_mux_if: bundles the seven-segment driver's control, load and pin signals.
//   en, load            scan enable and 1-cycle shadow-load strobe
//   hex_in/dp_in/blank_in  per-digit nibble, decimal point and blank request
//   sseg, an            active-low segment and anode outputs
//   digit_idx           digit currently scanned
//   frame_done          1-cycle pulse on the last cycle of the last digit
//   bright              global brightness (only with SSEG_DIMMING_EN)
// Modports: master drives the inputs, slave is the driver itself.
interface sseg_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  en;
  logic                  load;
  logic [4*N_DIGITS-1:0] hex_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [7:0]            sseg;
  logic [N_DIGITS-1:0]   an;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;
`ifdef SSEG_DIMMING_EN
  logic [3:0]            bright;

  modport master (
    output en, load, hex_in, dp_in, blank_in, bright,
    input  sseg, an, digit_idx, frame_done
  );

  modport slave (
    input  en, load, hex_in, dp_in, blank_in, bright,
    output sseg, an, digit_idx, frame_done
  );
`else
  modport master (
    output en, load, hex_in, dp_in, blank_in,
    input  sseg, an, digit_idx, frame_done
  );

  modport slave (
    input  en, load, hex_in, dp_in, blank_in,
    output sseg, an, digit_idx, frame_done
  );
`endif
endinterface

// File: rtl/sseg_mux_driver.sv
// sseg_mux_driver: time-multiplexed driver for N_DIGITS common-anode
// seven-segment digits with a built-in hex decoder, shadow-buffered loads
// that commit only at frame boundaries, per-digit decimal point and blanking.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    sseg_mux_if.slave (en, load, hex_in, dp_in, blank_in in;
//          sseg, an, digit_idx, frame_done out)
// Optional feature: define SSEG_DIMMING_EN to add the 4-bit bright input and
// PWM dimming of the anode drive.
module sseg_mux_driver #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  sseg_mux_if.slave  bus
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HEX_W = 4 * N_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                frame_done_q;
  logic                frame_done_nxt;

  // Shadow (loaded any time) and display (committed at frame end) copies
  logic [HEX_W-1:0]    sh_hex;
  logic [N_DIGITS-1:0] sh_dp;
  logic [N_DIGITS-1:0] sh_blank;
  logic [HEX_W-1:0]    disp_hex;
  logic [N_DIGITS-1:0] disp_dp;
  logic [N_DIGITS-1:0] disp_blank;
  logic                pending;
  logic                commit;

  // Output path
  logic [3:0]          sel_hex;
  logic                sel_dp;
  logic                sel_blank;
  logic                dim_on;
  logic                lit;
  logic [7:0]          sseg_q;
  logic [7:0]          sseg_nxt;
  logic [N_DIGITS-1:0] an_q;
  logic [N_DIGITS-1:0] an_nxt;

  // Active-low a..g pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] seg;
    case (h)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Slot counter / digit index advance; frame_done is registered by
  // predicting the next scan position so it lines up with the counter.
  always_comb begin : scan_next
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (!bus.en) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : IDX_W'(idx + 1'b1);
    end else begin
      cnt_nxt = CNT_W'(cnt + 1'b1);
    end
    frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  // Commit at the frame boundary, or immediately while the scan is disabled
  assign commit = pending && (frame_done_q || !bus.en);

`ifdef SSEG_DIMMING_EN
  logic [3:0] pwm;
  logic [3:0] bright_q;

  // Free-running PWM phase; brightness is latched at the start of every slot
  always_ff @(posedge clk or negedge rst_n) begin : dim_regs
    if (!rst_n) begin
      pwm      <= 4'h0;
      bright_q <= 4'h0;
    end else begin
      pwm <= 4'(pwm + 1'b1);
      if (cnt == '0) begin
        bright_q <= bus.bright;
      end
    end
  end

  assign dim_on = (pwm < bright_q);
`else
  assign dim_on = 1'b1;
`endif

  // Select the scanned digit's display data and decode the next pin state
  always_comb begin : out_next
    sel_hex   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    an_nxt    = '1;
    sseg_nxt  = 8'hFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_hex   = disp_hex[k*4 +: 4];
        sel_dp    = disp_dp[k];
        sel_blank = disp_blank[k];
      end
    end
    // Slot-counter==0 is the anti-ghost guard cycle: everything dark
    lit = bus.en && (cnt != '0) && !sel_blank && dim_on;
    if (lit) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          an_nxt[k] = 1'b0;
        end
      end
      sseg_nxt = {~sel_dp, hex_to_seg(sel_hex)};
    end
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin : main_regs
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      frame_done_q <= 1'b0;
      sh_hex       <= '0;
      sh_dp        <= '0;
      sh_blank     <= '1;
      disp_hex     <= '0;
      disp_dp      <= '0;
      disp_blank   <= '1;
      pending      <= 1'b0;
      sseg_q       <= 8'hFF;
      an_q         <= '1;
    end else begin
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      frame_done_q <= frame_done_nxt;
      sseg_q       <= sseg_nxt;
      an_q         <= an_nxt;
      if (commit) begin
        disp_hex   <= sh_hex;
        disp_dp    <= sh_dp;
        disp_blank <= sh_blank;
      end
      // A load on a commit cycle lands in the shadow and waits a frame
      if (bus.load) begin
        sh_hex   <= bus.hex_in;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
        pending  <= 1'b1;
      end else if (commit) begin
        pending  <= 1'b0;
      end
    end
  end

  assign bus.sseg       = sseg_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// tb_sseg_mux_driver: directed bench for sseg_mux_driver with N_DIGITS=4,
// REFRESH_DIV=4. Expected segment bytes per digit are written by hand; a
// small scan/commit model tracks which display content should be visible.
module tb_sseg_mux_driver;

  logic clk;
  logic rst_n;

  sseg_mux_if #(.N_DIGITS(4)) bus ();

  sseg_mux_driver #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Bench model: scan position and display / shadow contents
  int          pos      = 0;
  logic        fd_prev  = 1'b0;
  logic        b_pend   = 1'b0;
  logic [31:0] ld_tab   = 32'hFFFF_FFFF;
  logic [31:0] sh_tab   = 32'hFFFF_FFFF;
  logic [3:0]  sh_blank = 4'hF;
  logic [31:0] disp_tab = 32'hFFFF_FFFF;
  logic [3:0]  disp_blank = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pos        = 0;
    fd_prev    = 1'b0;
    b_pend     = 1'b0;
    sh_tab     = 32'hFFFF_FFFF;
    sh_blank   = 4'hF;
    disp_tab   = 32'hFFFF_FFFF;
    disp_blank = 4'hF;
  endtask

  // One clock: predict pins from the pre-edge state, then advance the model
  task automatic step(input string tag);
    logic       en_s;
    logic       ld_s;
    logic [3:0] bl_s;
    logic       cm;
    logic       act;
    int         pb;
    int         d;
    logic [3:0] ea;
    logic [7:0] es;
    en_s = bus.en;
    ld_s = bus.load;
    bl_s = bus.blank_in;
    pb   = pos;
    cm   = b_pend && (fd_prev || !en_s);
    @(posedge clk);
    #1;
    act = 1'b0;
    d   = 0;
    if (en_s) begin
      pos = pb + 1;
      d   = (pb / 4) % 4;
      act = (pb % 4) != 0;
    end else begin
      pos = 0;
    end
    ea = 4'hF;
    es = 8'hFF;
    if (act && !disp_blank[d]) begin
      ea = ~(4'b0001 << d);
      es = disp_tab[d*8 +: 8];
    end
    if (cm) begin
      disp_tab   = sh_tab;
      disp_blank = sh_blank;
    end
    if (ld_s) begin
      sh_tab   = ld_tab;
      sh_blank = bl_s;
      b_pend   = 1'b1;
    end else if (cm) begin
      b_pend = 1'b0;
    end
    fd_prev = en_s && ((pos % 16) == 15);
    chk({tag, ".an"}, 32'(bus.an), 32'(ea));
    chk({tag, ".sseg"}, 32'(bus.sseg), 32'(es));
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd_prev));
    chk({tag, ".digit_idx"}, 32'(bus.digit_idx), en_s ? 32'((pos / 4) % 4) : 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [15:0] hex, input logic [3:0] dp,
                         input logic [3:0] blank, input logic [31:0] tab);
    bus.hex_in   = hex;
    bus.dp_in    = dp;
    bus.blank_in = blank;
    ld_tab       = tab;
    bus.load     = 1'b1;
    step(tag);
    bus.load     = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.hex_in   = 16'h0;
    bus.dp_in    = 4'h0;
    bus.blank_in = 4'h0;
`ifdef SSEG_DIMMING_EN
    bus.bright   = 4'hF;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.sseg", 32'(bus.sseg), 32'hFF);
    chk("rst.an", 32'(bus.an), 32'hF);
    chk("rst.frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst.digit_idx", 32'(bus.digit_idx), 32'h0);

    // First frames after reset are dark; frame_done every 16 cycles
    model_reset();
    rst_n  = 1'b1;
    bus.en = 1'b1;
    run("dark", 32);

    // Decode: F,3,A,1 with dp on digit 2
    do_load("dec_ld", 16'h1A3F, 4'b0100, 4'b0000, {8'hCF, 8'h08, 8'h86, 8'hB8});
    run("dec", 40);

    // Two loads mid-frame: last wins, nothing tears before frame_done
    do_load("fb_ld1", 16'h1111, 4'b0000, 4'b0000, {8'hCF, 8'hCF, 8'hCF, 8'hCF});
    run("fb_a", 3);
    do_load("fb_ld2", 16'h2222, 4'b0000, 4'b0000, {8'h92, 8'h92, 8'h92, 8'h92});
    run("fb_b", 36);

    // Load on the frame_done cycle waits one more frame
    for (int i = 0; i < 20 && !fd_prev; i++) begin
      step("fd_seek");
    end
    chk("fd_seek.found", 32'(bus.frame_done), 32'h1);
    do_load("fd_ld", 16'h0000, 4'b0000, 4'b0000, {8'h81, 8'h81, 8'h81, 8'h81});
    run("fd_run", 36);

    // Blank digit 1; guard cycles stay dark
    do_load("blk_ld", 16'h2222, 4'b0000, 4'b0010, {8'h92, 8'h92, 8'h92, 8'h92});
    run("blk", 36);

    // Disabled: dark throughout, pending commits immediately
    bus.en = 1'b0;
    run("dis", 2);
    do_load("dis_ld", 16'h5555, 4'b0000, 4'b0000, {8'hA4, 8'hA4, 8'hA4, 8'hA4});
    run("dis", 6);
    bus.en = 1'b1;
    run("reen", 20);

    // Asynchronous reset mid-scan takes effect without a clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.sseg", 32'(bus.sseg), 32'hFF);
    chk("arst.an", 32'(bus.an), 32'hF);
    chk("arst.frame_done", 32'(bus.frame_done), 32'h0);
    chk("arst.digit_idx", 32'(bus.digit_idx), 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    run("post_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
